// File: rtl/axi_b_resp_tracker.sv
// In-order AXI write-response tracker: AW {id,user} FIFO popped by downstream completions into a registered B beat.
// Optional AXI_B_DECERR_EN adds done_decerr_i, which returns DECERR with priority over SLVERR.
module axi_b_resp_tracker #(
    parameter int ID_WIDTH     = 4,
    parameter int USER_WIDTH   = 1,
    parameter int BUFFER_DEPTH = 4,
    localparam int CNT_W       = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  aw_valid_i,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [USER_WIDTH-1:0] aw_user_i,
    output logic                  aw_ready_o,
    input  logic                  done_valid_i,
    input  logic                  done_err_i,
`ifdef AXI_B_DECERR_EN
    input  logic                  done_decerr_i,
`endif
    output logic                  done_ready_o,
    output logic                  b_valid_o,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o,
    output logic [USER_WIDTH-1:0] b_user_o,
    input  logic                  b_ready_i,
    output logic [CNT_W-1:0]      outstanding_o
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int ENT_W = ID_WIDTH + USER_WIDTH;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_B_DECERR_EN
    localparam logic [1:0] RESP_DECERR = 2'b11;
`endif

    logic [ENT_W-1:0]      mem_reg [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  b_valid_reg, b_valid_next;
    logic [ID_WIDTH-1:0]   b_id_reg, b_id_next;
    logic [1:0]            b_resp_reg, b_resp_next;
    logic [USER_WIDTH-1:0] b_user_reg, b_user_next;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [1:0]       pop_resp;
    logic [ENT_W-1:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // The occupancy counter alone decides full/empty, so pointer equality is never needed.
    assign full  = (count_reg == CNT_FULL);
    assign empty = (count_reg == '0);

    assign aw_ready_o   = !full;
    assign done_ready_o = !empty && (!b_valid_reg || b_ready_i);
    assign push         = aw_valid_i && aw_ready_o;
    assign pop          = done_valid_i && done_ready_o;
    assign head         = mem_reg[rd_ptr_reg];

    always_comb begin
        pop_resp = RESP_OKAY;
`ifdef AXI_B_DECERR_EN
        if (done_decerr_i) begin
            pop_resp = RESP_DECERR;
        end else if (done_err_i) begin
            pop_resp = RESP_SLVERR;
        end
`else
        if (done_err_i) begin
            pop_resp = RESP_SLVERR;
        end
`endif
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // A pop in the handshake cycle reloads the beat, keeping b_valid high back-to-back.
    always_comb begin
        b_valid_next = b_valid_reg;
        b_id_next    = b_id_reg;
        b_resp_next  = b_resp_reg;
        b_user_next  = b_user_reg;
        if (pop) begin
            b_valid_next = 1'b1;
            b_id_next    = head[ENT_W-1:USER_WIDTH];
            b_user_next  = head[USER_WIDTH-1:0];
            b_resp_next  = pop_resp;
        end else if (b_valid_reg && b_ready_i) begin
            b_valid_next = 1'b0;
        end
    end

    // Storage has no reset; pointers and count flush it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= {aw_id_i, aw_user_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            b_valid_reg <= 1'b0;
            b_id_reg    <= '0;
            b_resp_reg  <= RESP_OKAY;
            b_user_reg  <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            b_valid_reg <= b_valid_next;
            b_id_reg    <= b_id_next;
            b_resp_reg  <= b_resp_next;
            b_user_reg  <= b_user_next;
        end
    end

    assign b_valid_o     = b_valid_reg;
    assign b_id_o        = b_id_reg;
    assign b_resp_o      = b_resp_reg;
    assign b_user_o      = b_user_reg;
    assign outstanding_o = count_reg;

endmodule

// File: tb/tb_axi_b_resp_tracker.sv
// Directed bench for axi_b_resp_tracker: queue-based model checked every cycle plus literal spot checks.
module tb_axi_b_resp_tracker;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       aw_valid = 1'b0;
    logic [3:0] aw_id = '0;
    logic       aw_user = 1'b0;
    logic       aw_ready;
    logic       done_valid = 1'b0;
    logic       done_err = 1'b0;
`ifdef AXI_B_DECERR_EN
    logic       done_decerr = 1'b0;
`endif
    logic       done_ready;
    logic       b_valid;
    logic [3:0] b_id;
    logic [1:0] b_resp;
    logic       b_user;
    logic       b_ready = 1'b0;
    logic [2:0] outstanding;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    axi_b_resp_tracker #(
        .ID_WIDTH(4),
        .USER_WIDTH(1),
        .BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .aw_valid_i(aw_valid),
        .aw_id_i(aw_id),
        .aw_user_i(aw_user),
        .aw_ready_o(aw_ready),
        .done_valid_i(done_valid),
        .done_err_i(done_err),
`ifdef AXI_B_DECERR_EN
        .done_decerr_i(done_decerr),
`endif
        .done_ready_o(done_ready),
        .b_valid_o(b_valid),
        .b_id_o(b_id),
        .b_resp_o(b_resp),
        .b_user_o(b_user),
        .b_ready_i(b_ready),
        .outstanding_o(outstanding)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of outstanding writes and the pending B beat.
    typedef struct packed {
        logic [3:0] id;
        logic       user;
    } ent_t;

    ent_t       q[$];
    logic       m_valid = 1'b0;
    logic [3:0] m_id = '0;
    logic       m_user = 1'b0;
    logic [1:0] m_resp = 2'b00;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic exp_aw_ready;
                logic exp_done_ready;
                ent_t hd;
                exp_aw_ready   = (q.size() < DEPTH);
                exp_done_ready = (q.size() > 0) && (!m_valid || b_ready);
                check("aw_ready", 32'(aw_ready), 32'(exp_aw_ready));
                check("done_ready", 32'(done_ready), 32'(exp_done_ready));
                check("outstanding", 32'(outstanding), 32'(q.size()));
                check("b_valid", 32'(b_valid), 32'(m_valid));
                if (m_valid) begin
                    check("b_id", 32'(b_id), 32'(m_id));
                    check("b_user", 32'(b_user), 32'(m_user));
                    check("b_resp", 32'(b_resp), 32'(m_resp));
                end
                // Advance the model with the inputs the coming edge will sample.
                if (rst) begin
                    q.delete();
                    m_valid = 1'b0;
                    m_id    = '0;
                    m_user  = 1'b0;
                    m_resp  = 2'b00;
                end else begin
                    if (m_valid && b_ready) begin
                        $display("B handshake id=%0h user=%0b resp=%02b", m_id, m_user, m_resp);
                    end
                    if (done_valid && exp_done_ready) begin
                        hd      = q.pop_front();
                        m_valid = 1'b1;
                        m_id    = hd.id;
                        m_user  = hd.user;
`ifdef AXI_B_DECERR_EN
                        m_resp  = done_decerr ? 2'b11 : (done_err ? 2'b10 : 2'b00);
`else
                        m_resp  = done_err ? 2'b10 : 2'b00;
`endif
                    end else if (m_valid && b_ready) begin
                        m_valid = 1'b0;
                    end
                    if (aw_valid && exp_aw_ready) begin
                        q.push_back('{id: aw_id, user: aw_user});
                    end
                end
            end
        end
    end

    task automatic drive(input int awv, input int id, input int usr, input int dv, input int err, input int br);
        aw_valid   = awv[0];
        aw_id      = id[3:0];
        aw_user    = usr[0];
        done_valid = dv[0];
        done_err   = err[0];
        b_ready    = br[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        chk_en = 1'b1;
        #1;
        tick();
        #2;
        check("rst aw_ready", 32'(aw_ready), 32'd1);
        check("rst done_ready", 32'(done_ready), 32'd0);
        check("rst b_valid", 32'(b_valid), 32'd0);
        check("rst b_id", 32'(b_id), 32'd0);
        check("rst b_resp", 32'(b_resp), 32'd0);
        check("rst b_user", 32'(b_user), 32'd0);
        check("rst outstanding", 32'(outstanding), 32'd0);
        rst = 1'b0;
        tick();

        // Single write
        drive(1, 3, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 1, 0, 0);
        #2;
        check("single done_ready", 32'(done_ready), 32'd1);
        check("single outstanding1", 32'(outstanding), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check("single b_valid", 32'(b_valid), 32'd1);
        check("single b_id", 32'(b_id), 32'd3);
        check("single b_user", 32'(b_user), 32'd1);
        check("single b_resp", 32'(b_resp), 32'd0);
        check("single outstanding0", 32'(outstanding), 32'd0);
        tick();
        #2;
        check("single hold b_id", 32'(b_id), 32'd3);
        check("single hold b_valid", 32'(b_valid), 32'd1);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check("single cleared", 32'(b_valid), 32'd0);
        tick();

        // Fill and stall
        for (int i = 0; i < 4; i++) begin
            drive(1, i, 0, 0, 0, 0);
            tick();
        end
        drive(1, 4, 0, 0, 0, 0);
        #2;
        check("full aw_ready", 32'(aw_ready), 32'd0);
        check("full outstanding", 32'(outstanding), 32'd4);
        tick();
        drive(1, 4, 0, 1, 0, 1);
        #2;
        check("full pop aw_ready", 32'(aw_ready), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #2;
        check("after pop aw_ready", 32'(aw_ready), 32'd1);
        check("after pop outstanding", 32'(outstanding), 32'd3);
        check("after pop b_id", 32'(b_id), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();

        // Order plus back-to-back, SLVERR on the middle beat
        drive(1, 5, 0, 0, 0, 1);
        tick();
        drive(1, 9, 1, 0, 0, 1);
        tick();
        drive(1, 2, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 1, 1, 1);
        #2;
        check("order b_id0", 32'(b_id), 32'd5);
        check("order b_resp0", 32'(b_resp), 32'd0);
        tick();
        drive(0, 0, 0, 1, 0, 1);
        #2;
        check("order b_id1", 32'(b_id), 32'd9);
        check("order b_resp1", 32'(b_resp), 32'd2);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #2;
        check("order b_id2", 32'(b_id), 32'd2);
        check("order b_resp2", 32'(b_resp), 32'd0);
        check("order b_valid2", 32'(b_valid), 32'd1);
        tick();

        // Backpressure
        drive(1, 7, 0, 0, 0, 0);
        tick();
        drive(1, 8, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        #2;
        check("bp done_ready", 32'(done_ready), 32'd0);
        check("bp outstanding", 32'(outstanding), 32'd1);
        tick();
        #2;
        check("bp b_id stable", 32'(b_id), 32'd7);
        check("bp outstanding stable", 32'(outstanding), 32'd1);
        drive(0, 0, 0, 1, 0, 1);
        #2;
        check("bp release done_ready", 32'(done_ready), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #2;
        check("bp next b_id", 32'(b_id), 32'd8);
        tick();

        // Simultaneous push/pop with pointer wrap
        drive(1, 10, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, i, i & 1, 1, (i == 4) ? 1 : 0, 1);
            #2;
            check("pair outstanding", 32'(outstanding), 32'd1);
            tick();
        end
        drive(0, 0, 0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #2;
        check("pair last b_id", 32'(b_id), 32'd9);
        tick();

        // Reset mid-operation
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check("pre-rst b_valid", 32'(b_valid), 32'd1);
        check("pre-rst outstanding", 32'(outstanding), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 1, 0, 1);
        #2;
        check("mid-rst b_valid", 32'(b_valid), 32'd0);
        check("mid-rst outstanding", 32'(outstanding), 32'd0);
        check("mid-rst done_ready", 32'(done_ready), 32'd0);
        check("mid-rst aw_ready", 32'(aw_ready), 32'd1);
        check("mid-rst b_id", 32'(b_id), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check("post-rst no pop", 32'(b_valid), 32'd0);
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_b_resp_tracker.md
# axi_b_resp_tracker

Write-response end of the AXI slave path. Every accepted AW beat pushes its ID and USER into an in-order FIFO. A completion pulse from the downstream write engine (for example APB transfer done) pops the oldest entry and presents a registered B beat with the matching ID and response code. It sits beside the AW channel buffer and closes each write transaction that buffer forwarded.

## Interface
- ID_WIDTH, 4, width of AW/B ID fields
- USER_WIDTH, 1, width of AW/B USER fields
- BUFFER_DEPTH, 4, maximum outstanding writes; legal values are ≥1 and need not be a power of two
- clk_i  input  1  sole clock; all logic on its rising edge
- rst_i  input  1  synchronous, active-high reset
- aw_valid_i  input  1  AW beat accepted by the slave path
- aw_id_i  input  ID_WIDTH  AW ID to track
- aw_user_i  input  USER_WIDTH  AW USER to echo on B
- aw_ready_o  output  1  space available in the tracker
- done_valid_i  input  1  oldest write has completed downstream
- done_err_i  input  1  completion ended in error
- done_ready_o  output  1  completion accepted
- b_valid_o  output  1  B beat valid
- b_id_o  output  ID_WIDTH  B ID
- b_resp_o  output  2  B response
- b_user_o  output  USER_WIDTH  B USER
- b_ready_i  input  1  master accepts B
- outstanding_o  output  $clog2(BUFFER_DEPTH+1)  FIFO occupancy

## Operation
- **Storage**
  - FIFO of {id, user} with BUFFER_DEPTH entries.
  - Write and read pointers wrap from BUFFER_DEPTH-1 to 0.
  - Occupancy counter is the sole full/empty source: full when count == BUFFER_DEPTH, empty when count == 0.
- **Push**
  - aw_ready_o = !full.
  - On aw_valid_i && aw_ready_o, write the entry at the write pointer and advance the pointer.
- **Pop**
  - done_ready_o = !empty && (!b_valid_o || b_ready_i).
  - On done_valid_i && done_ready_o:
    - Load the B register from the FIFO head: b_id_o, b_user_o.
    - b_resp_o = done_err_i ? 2'b10 (SLVERR) : 2'b00 (OKAY).
    - Set b_valid_o and advance the read pointer.
- **B channel**
  - b_valid_o holds with stable payload until b_valid_o && b_ready_i.
  - If no new pop occurs in the handshake cycle, b_valid_o clears the next cycle.
  - Back-to-back: handshake and pop in the same cycle reload the register, and b_valid_o stays high.
- **Simultaneous push and pop:** both take effect and count is unchanged.
- **No bypass**
  - An AW pushed into an empty FIFO cannot be popped in the same cycle, because done_ready_o is 0 while empty.
  - When full, aw_ready_o is 0 even if a pop happens that cycle.
- **done_valid_i while empty:** stalls with done_ready_o low. It is not an error and causes no underflow.
- **Ordering:** strictly in order. IDs are never reordered and the ID value is never interpreted.

## Timing
- **Reset values:**
  - aw_ready_o = 1
  - done_ready_o = 0
  - b_valid_o = 0
  - b_id_o = 0
  - b_resp_o = 2'b00
  - b_user_o = 0
  - outstanding_o = 0
  - pointers = 0
- **Reset mid-operation:** flushes all entries and drops any pending B beat without a handshake.
- **Latency:**
  - AW push to entry poppable: 1 cycle.
  - Completion handshake to b_valid_o high: 1 cycle.
  - Sustained throughput is one B per cycle when b_ready_i is held high.
- **Combinational paths:**
  - aw_ready_o depends only on registered state.
  - done_ready_o depends combinationally on b_ready_i only.
- **outstanding_o:** counts entries still in the FIFO, not the B beat held in the output register.

## Configuration
- Macro **AXI_B_DECERR_EN**.
- **Defined:**
  - Adds input done_decerr_i (1 bit).
  - On pop, b_resp_o = done_decerr_i ? 2'b11 (DECERR) : done_err_i ? 2'b10 : 2'b00, so DECERR has priority over SLVERR.
- **Undefined:**
  - Port is absent.
  - b_resp_o only ever takes 2'b00 or 2'b10.

## Test plan
- **Single write:** push AW id=3, user=1; done_valid_i with err=0 two cycles later → next cycle b_valid_o=1, b_id_o=3, b_user_o=1, b_resp_o=00; b_valid_o holds until b_ready_i; outstanding_o goes 1→0.
- **Fill and stall:** with BUFFER_DEPTH=4, push ids 0..3 → aw_ready_o=0 and outstanding_o=4; a 5th AW stalls; one pop → aw_ready_o=1 the next cycle.
- **Order plus back-to-back:** push ids 5, 9, 2 with b_ready_i=1 and done_valid_i held high → B ids 5, 9, 2 on consecutive cycles; SLVERR on the second when done_err_i=1 for that beat only.
- **Backpressure:** b_ready_i=0 with b_valid_o=1 → done_ready_o=0, B payload stable, FIFO count unchanged; raising b_ready_i → next completion accepted in the same cycle.
- **Simultaneous push/pop and wrap:** run 10 push+pop pairs at DEPTH=4 → pointers wrap and all IDs return in order; outstanding_o is constant during the simultaneous cycles.
- **Reset mid-operation:** assert rst_i with 3 entries and b_valid_o=1 → next cycle all outputs at reset values; a following done_valid_i is not accepted.
